// File: rtl/hue_window_mask_pkg.sv
// hue_window_mask_pkg: shared coordinate type and window-geometry helpers for hue_window_mask.
package hue_window_mask_pkg;
  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;
  function automatic int half(input int n);
    return n / 2;
  endfunction
  function automatic int def_threshold(input int n);
    return (n * n + 1) / 2;
  endfunction
endpackage

// File: rtl/hue_window_mask_row_buffer.sv
// mask_row_buffer: DEPTH-deep, W-wide delay line that advances only when en is high.
module mask_row_buffer #(
  parameter int W = 2,
  parameter int DEPTH = 640
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr_q;
  assign q = mem[ptr_q];
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else if (en) ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  always_ff @(posedge clk)
    if (en) mem[ptr_q] <= d;
endmodule

// File: rtl/hue_window_mask.sv
// hue_window_mask: classifies each pixel against NUM_RANGES (possibly wrapping) hue bands
// and smooths every band mask with a trailing N x N popcount-threshold window.
module hue_window_mask
  import hue_window_mask_pkg::*;
#(
  parameter int PRECISION  = 16,
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480,
  parameter int N          = 3,
  parameter int NUM_RANGES = 2,
  parameter int THRESHOLD  = def_threshold(N)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [PRECISION-1:0]             in_hue,
  input  logic [NUM_RANGES*PRECISION-1:0]  range_lo,
  input  logic [NUM_RANGES*PRECISION-1:0]  range_hi,
  input  logic [NUM_RANGES-1:0]            range_en,
  output logic                             out_valid,
  output logic [NUM_RANGES-1:0]            out_mask,
  output coord_t                           out_x,
  output coord_t                           out_y,
  output logic                             out_sof
);
  localparam int H = half(N);
  logic [NUM_RANGES*PRECISION-1:0] lo_q, hi_q, lo_e, hi_e;
  logic [NUM_RANGES-1:0] en_q, en_e, cls, mask_d;
  logic [N-1:0][NUM_RANGES-1:0] col;
  logic [NUM_RANGES-1:0] win_q [N][N];
  coord_t x_q, y_q, cur_x, cur_y, x_d, y_d, x1_q, y1_q;
  logic sof_acc, last_x, v1_q, emit;
  int cnt;
  // A sof pixel is classified with the freshly loaded band config.
  assign sof_acc = in_valid && in_sof;
  assign lo_e = sof_acc ? range_lo : lo_q;
  assign hi_e = sof_acc ? range_hi : hi_q;
  assign en_e = sof_acc ? range_en : en_q;
  assign cur_x = in_sof ? '0 : x_q;
  assign cur_y = in_sof ? '0 : y_q;
  assign last_x = cur_x == coord_t'(LINE_WIDTH - 1);
  assign x_d = last_x ? '0 : cur_x + 1'b1;
  assign y_d = !last_x ? cur_y : (cur_y == coord_t'(ROW_NUMBER - 1)) ? '0 : cur_y + 1'b1;
  for (genvar k = 0; k < NUM_RANGES; k++) begin : g_band
    logic [PRECISION-1:0] lo, hi;
    assign lo = lo_e[k*PRECISION +: PRECISION];
    assign hi = hi_e[k*PRECISION +: PRECISION];
    assign cls[k] = en_e[k] && ((lo <= hi) ? (in_hue >= lo && in_hue <= hi)
                                           : (in_hue >= lo || in_hue <= hi));
  end
  assign col[0] = cls;
  for (genvar r = 0; r < N - 1; r++) begin : g_row
    mask_row_buffer #(.W(NUM_RANGES), .DEPTH(LINE_WIDTH)) u_rb (
      .clk(clk), .rst(rst), .en(in_valid), .d(col[r]), .q(col[r+1])
    );
  end
  always_ff @(posedge clk)
    if (in_valid)
      for (int r = 0; r < N; r++) begin
        win_q[r][0] <= col[r];
        for (int c = 1; c < N; c++) win_q[r][c] <= win_q[r][c-1];
      end
  // Tap (r,c) sits r rows above and c columns left of the newest pixel; negative positions are masked.
  always_comb begin
    mask_d = '0;
    cnt = 0;
    for (int k = 0; k < NUM_RANGES; k++) begin
      cnt = 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (int'(x1_q) >= c && int'(y1_q) >= r && win_q[r][c][k]) cnt = cnt + 1;
      mask_d[k] = cnt >= THRESHOLD;
    end
  end
  assign emit = v1_q && int'(x1_q) >= H && int'(y1_q) >= H;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lo_q <= '0;
      hi_q <= '0;
      en_q <= '0;
      x_q <= '0;
      y_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      v1_q <= 1'b0;
      out_valid <= 1'b0;
      out_mask <= '0;
      out_x <= '0;
      out_y <= '0;
      out_sof <= 1'b0;
    end else begin
      if (sof_acc) begin
        lo_q <= range_lo;
        hi_q <= range_hi;
        en_q <= range_en;
      end
      if (in_valid) begin
        x_q <= x_d;
        y_q <= y_d;
        x1_q <= cur_x;
        y1_q <= cur_y;
      end
      v1_q <= in_valid;
      out_valid <= emit;
      if (emit) begin
        out_mask <= mask_d;
        out_x <= x1_q - coord_t'(H);
        out_y <= y1_q - coord_t'(H);
        out_sof <= x1_q == coord_t'(H) && y1_q == coord_t'(H);
      end
    end
endmodule

// File: tb/tb_hue_window_mask.sv
// tb_hue_window_mask: directed-vector bench with a centred-window reference model and
// cycle-stamped output stream comparison.
module tb_hue_window_mask;
  localparam int LW = 8, RN = 6;
  typedef logic [50:0] ent_t;
  logic clk = 0, rst = 0, in_valid = 0, in_sof = 0;
  logic [15:0] in_hue = '0;
  logic [31:0] range_lo = '0, range_hi = '0;
  logic [1:0] range_en = '0;
  logic out_valid, out_sof;
  logic [1:0] out_mask;
  logic [15:0] out_x, out_y;
  ent_t got_q[$], exp_q[$];
  int cyc = 0, n_vec = 0, n_err = 0, bx = 0, by = 0;
  logic [15:0] s_lo [2], s_hi [2];
  logic [1:0] s_en = '0;
  logic [1:0] cls_m [RN][LW];
  logic [15:0] img [RN][LW];
  bit cfg_sw = 0;

  hue_window_mask #(.PRECISION(16), .LINE_WIDTH(LW), .ROW_NUMBER(RN), .N(3),
                    .NUM_RANGES(2), .THRESHOLD(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_hue(in_hue),
    .range_lo(range_lo), .range_hi(range_hi), .range_en(range_en),
    .out_valid(out_valid), .out_mask(out_mask), .out_x(out_x), .out_y(out_y), .out_sof(out_sof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst && out_valid) got_q.push_back({cyc[15:0], out_x, out_y, out_mask, out_sof});

  function automatic logic in_band(input logic [15:0] h, lo, hi, input logic en);
    return en && ((lo <= hi) ? (h >= lo && h <= hi) : (h >= lo || h <= hi));
  endfunction

  function automatic logic [1:0] win_mask(input int cx, input int cy);
    logic [1:0] m;
    int n;
    m = '0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if (cx + dx >= 0 && cy + dy >= 0) n += int'(cls_m[cy+dy][cx+dx][k]);
      m[k] = n >= 5;
    end
    return m;
  endfunction

  task automatic model_reset();
    bx = 0; by = 0; s_en = '0;
    for (int k = 0; k < 2; k++) begin s_lo[k] = '0; s_hi[k] = '0; end
  endtask

  task automatic send_px(input bit v, input bit s, input logic [15:0] h);
    @(negedge clk);
    in_valid = v; in_sof = s; in_hue = h;
    if (v) begin
      if (s) begin
        bx = 0; by = 0; s_en = range_en;
        for (int k = 0; k < 2; k++) begin s_lo[k] = range_lo[k*16 +: 16]; s_hi[k] = range_hi[k*16 +: 16]; end
      end
      for (int k = 0; k < 2; k++) cls_m[by][bx][k] = in_band(h, s_lo[k], s_hi[k], s_en[k]);
      if (bx >= 1 && by >= 1)
        exp_q.push_back({cyc[15:0] + 16'd2, 16'(bx - 1), 16'(by - 1), win_mask(bx - 1, by - 1), bx == 1 && by == 1});
      if (bx == LW - 1) begin bx = 0; by = (by == RN - 1) ? 0 : by + 1; end
      else bx = bx + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send_px(0, 0, '0);
  endtask

  task automatic run_frame(input bit sof, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(1) == 1) send_px(0, 0, '0);
      if (cfg_sw && i == 2 * LW + 3) begin range_lo[15:0] = 16'd0; range_hi[15:0] = 16'd10; end
      send_px(1, sof && i == 0, img[i / LW][i % LW]);
    end
  endtask

  task automatic fill(input logic [15:0] h);
    for (int y = 0; y < RN; y++) for (int x = 0; x < LW; x++) img[y][x] = h;
  endtask

  task automatic set_bands(input logic [15:0] lo0, hi0);
    range_lo = {16'd200, lo0}; range_hi = {16'd250, hi0}; range_en = 2'b11;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({out_valid, out_mask, out_x, out_y, out_sof} !== 36'd0) begin
      n_err++; $display("FAIL reset_state got %h want 0", {out_valid, out_mask, out_x, out_y, out_sof});
    end
    rst = 1;
    idle(3);
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL reset_idle got %0d outputs want 0", got_q.size()); end
  endtask

  task automatic test_uniform();
    got_q.delete(); exp_q.delete();
    set_bands(16'd80, 16'd120); fill(16'd100);
    run_frame(1, 0, LW * RN); idle(4);
    n_vec++;
    if (got_q.size() != 35 || exp_q.size() != 35) begin n_err++; $display("FAIL uniform_count got %0d want 35", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL uniform[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_vec += 3;
    if (got_q[0][34:0] !== {16'd0, 16'd0, 2'b00, 1'b1}) begin n_err++; $display("FAIL uniform_00 got %h want 0000000001", got_q[0][34:0]); end
    if (got_q[7][34:0] !== {16'd0, 16'd1, 2'b01, 1'b0}) begin n_err++; $display("FAIL uniform_01 got %h want 0000000a", got_q[7][34:0]); end
    if (got_q[8][34:0] !== {16'd1, 16'd1, 2'b01, 1'b0}) begin n_err++; $display("FAIL uniform_11 got %h", got_q[8][34:0]); end
  endtask

  task automatic test_wrap();
    logic [15:0] hv [5];
    logic ev [5];
    hv = '{16'hFF00, 16'h0100, 16'h8000, 16'hF000, 16'h0800};
    ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    set_bands(16'hF000, 16'h0800);
    for (int t = 0; t < 5; t++) begin
      got_q.delete(); exp_q.delete();
      fill(hv[t]);
      run_frame(1, 0, LW * RN); idle(4);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap[%0d][%0d] got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      n_vec++;
      if (got_q[17][1] !== ev[t]) begin n_err++; $display("FAIL wrap_centre hue %h got %b want %b", hv[t], got_q[17][1], ev[t]); end
    end
  endtask

  task automatic test_speckle();
    set_bands(16'd80, 16'd120);
    for (int t = 0; t < 2; t++) begin
      got_q.delete(); exp_q.delete();
      fill(16'd500);
      if (t == 0) img[3][4] = 16'd100;
      else for (int y = 2; y <= 4; y++) for (int x = 3; x <= 5; x++) img[y][x] = 16'd100;
      run_frame(1, 0, LW * RN); idle(4);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL speckle_count[%0d] got %0d want %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL speckle[%0d][%0d] got %h want %h", t, i, got_q[i], exp_q[i]); end
        if (t == 0) begin
          n_vec++;
          if (got_q[i][2:1] !== 2'b00) begin n_err++; $display("FAIL speckle_zero[%0d] got %b want 00", i, got_q[i][2:1]); end
        end
      end
    end
    n_vec += 2;
    if (got_q[25][2:1] !== 2'b01) begin n_err++; $display("FAIL block_43 got %b want 01", got_q[25][2:1]); end
    if (got_q[9][2:1] !== 2'b00) begin n_err++; $display("FAIL block_21 got %b want 00", got_q[9][2:1]); end
  endtask

  task automatic test_config_isolation();
    set_bands(16'd80, 16'd120); fill(16'd100);
    for (int t = 0; t < 2; t++) begin
      got_q.delete(); exp_q.delete();
      cfg_sw = (t == 0);
      run_frame(1, 0, LW * RN); idle(4);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL cfg_count[%0d] got %0d want %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cfg[%0d][%0d] got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      n_vec++;
      if (got_q[30][2:1] !== (t == 0 ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL cfg_24[%0d] got %b", t, got_q[30][2:1]); end
    end
    cfg_sw = 0;
  endtask

  task automatic test_valid_gaps();
    set_bands(16'd80, 16'd120); fill(16'd100);
    for (int t = 0; t < 2; t++) begin
      got_q.delete(); exp_q.delete();
      run_frame(t == 0, t == 0, LW * RN); idle(4);
      n_vec++;
      if (got_q.size() != 35 || exp_q.size() != 35) begin n_err++; $display("FAIL gaps_count[%0d] got %0d want 35", t, got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gaps[%0d][%0d] got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      n_vec += 2;
      if (got_q[34][34:3] !== {16'd6, 16'd4}) begin n_err++; $display("FAIL gaps_last[%0d] got %h want 00060004", t, got_q[34][34:3]); end
      if (got_q[0][34:0] !== {16'd0, 16'd0, 2'b00, 1'b1}) begin n_err++; $display("FAIL gaps_first[%0d] got %h want 0000000001", t, got_q[0][34:0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    set_bands(16'd80, 16'd120); fill(16'd100);
    got_q.delete(); exp_q.delete();
    run_frame(1, 0, 30);
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
    #2 rst = 0;
    #1;
    n_vec++;
    if ({out_valid, out_mask, out_x, out_y, out_sof} !== 36'd0) begin
      n_err++; $display("FAIL async_reset got %h want 0", {out_valid, out_mask, out_x, out_y, out_sof});
    end
    in_valid = 0; in_sof = 0;
    model_reset();
    got_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    for (int t = 0; t < 2; t++) begin
      got_q.delete(); exp_q.delete();
      run_frame(t == 1, 0, LW * RN); idle(4);
      n_vec++;
      if (got_q.size() != 35 || exp_q.size() != 35) begin n_err++; $display("FAIL rst_count[%0d] got %0d want 35", t, got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst[%0d][%0d] got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      n_vec += 2;
      if (got_q[0][34:0] !== {16'd0, 16'd0, 2'b00, 1'b1}) begin n_err++; $display("FAIL rst_00[%0d] got %h", t, got_q[0][34:0]); end
      if (got_q[8][34:0] !== {16'd1, 16'd1, (t == 1) ? 2'b01 : 2'b00, 1'b0}) begin n_err++; $display("FAIL rst_11[%0d] got %h", t, got_q[8][34:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_wrap();
    test_speckle();
    test_config_isolation();
    test_valid_gaps();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
